program_sequencer: RTL and testbench



---
 rtl/program_sequencer_pkg.sv | 24 ++
 rtl/program_sequencer_stack.sv | 52 +++++
 rtl/program_sequencer.sv | 141 ++++++++++++++
 tb/tb_program_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: default widths, the pm_addr
// source selector and the jump-target helper.
package program_sequencer_pkg;

  localparam int DEF_PC_W        = 8;
  localparam int DEF_NIB_W       = 4;
  localparam int DEF_STACK_DEPTH = 4;

  // Which source drives pm_addr this cycle, listed in priority order.
  typedef enum logic [2:0] {
    SRC_RESET = 3'd0,
    SRC_HOLD  = 3'd1,
    SRC_RET   = 3'd2,
    SRC_CALL  = 3'd3,
    SRC_JMP   = 3'd4,
    SRC_INC   = 3'd5
  } addr_src_e;

  // Jump target at the default widths. The nibble selects a 16-byte page.
  function automatic logic [DEF_PC_W-1:0] jump_target(input logic [DEF_NIB_W-1:0] nib);
    return {nib, {(DEF_PC_W-DEF_NIB_W){1'b0}}};
  endfunction

endpackage

// File: rtl/program_sequencer_stack.sv
// seq_return_stack: LIFO of return addresses for hardware call/return.
// Only instantiated when SEQ_CALL_STACK_EN is defined. Push and pop are never
// requested together by the sequencer; if they were, pop wins.
module seq_return_stack
  import program_sequencer_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = DEF_STACK_DEPTH
) (
  input  logic            clk,
  input  logic            sync_reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - CNT_W'(1));
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign top     = mem[top_idx];

  // Occupancy count; reset discards every entry.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      count <= '0;
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end
  end

  // Entry storage; contents above the count are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (sync_reset_n && push && !pop && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: program-memory fetch address generator.
// pm_addr is combinational so the ROM sees the redirect in the same cycle;
// pc follows pm_addr one clock later.
// Optional feature macro: SEQ_CALL_STACK_EN enables the call/return stack.
// Without it call/ret are ignored and stack_err is tied low.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int NIB_W       = DEF_NIB_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             sync_reset_n,
  input  logic             jmp,
  input  logic             jmp_nz,
  input  logic [NIB_W-1:0] jmp_addr,
  input  logic             dont_jmp,
  input  logic             hold,
  input  logic             call,
  input  logic             ret,
  output logic [PC_W-1:0]  pm_addr,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  from_PS,
  output logic             jmp_taken,
  output logic             stack_err
);

  addr_src_e       src;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] stack_top;
  logic            redirect;

  assign pc_inc   = pc + PC_W'(1);
  assign target   = {jmp_addr, {(PC_W-NIB_W){1'b0}}};
  assign redirect = (src == SRC_RET) || (src == SRC_CALL) || (src == SRC_JMP);
  assign from_PS  = pc;

`ifdef SEQ_CALL_STACK_EN
  logic stack_full;
  logic stack_empty;
  logic push;
  logic pop;
  logic err_set;
  logic stack_err_q;

  assign push      = (src == SRC_CALL) && !stack_full;
  assign pop       = (src == SRC_RET);
  assign stack_err = stack_err_q;

  seq_return_stack #(
    .PC_W  (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .push         (push),
    .pop          (pop),
    .push_data    (pc_inc),
    .top          (stack_top),
    .full         (stack_full),
    .empty        (stack_empty)
  );

  // Source select in priority order, plus the stack error condition.
  // A ret on an empty stack falls through to pc+1 and is not a redirect.
  always_comb begin
    src     = SRC_INC;
    err_set = 1'b0;
    if (!sync_reset_n) begin
      src = SRC_RESET;
    end else if (hold) begin
      src = SRC_HOLD;
    end else if (ret) begin
      if (stack_empty) begin
        err_set = 1'b1;
      end else begin
        src = SRC_RET;
      end
    end else if (call) begin
      src     = SRC_CALL;
      err_set = stack_full;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      src = SRC_JMP;
    end
  end

  // Sticky over/underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      stack_err_q <= 1'b0;
    end else if (err_set) begin
      stack_err_q <= 1'b1;
    end
  end
`else
  logic unused_stack_ctrl;
  localparam int unused_stack_depth = STACK_DEPTH;

  assign unused_stack_ctrl = call ^ ret;
  assign stack_top         = '0;
  assign stack_err         = 1'b0;

  // Source select in priority order; call/ret have no effect in this build.
  always_comb begin
    src = SRC_INC;
    if (!sync_reset_n) begin
      src = SRC_RESET;
    end else if (hold) begin
      src = SRC_HOLD;
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      src = SRC_JMP;
    end
  end
`endif

  // Fetch address mux driven by the selected source.
  always_comb begin
    case (src)
      SRC_RESET: pm_addr = '0;
      SRC_HOLD:  pm_addr = pc;
      SRC_RET:   pm_addr = stack_top;
      SRC_CALL,
      SRC_JMP:   pm_addr = target;
      default:   pm_addr = pc_inc;
    endcase
  end

  // PC follows the fetch address; jmp_taken records a redirect this cycle.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      pc        <= '0;
      jmp_taken <= 1'b0;
    end else begin
      pc        <= pm_addr;
      jmp_taken <= redirect;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: directed steps from the behaviour list
// followed by random control traffic, all checked against a reference model
// that keeps pc, flags and the return stack as plain variables and a queue.
module tb_program_sequencer;

`ifdef SEQ_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       sync_reset_n;
  logic       jmp, jmp_nz, dont_jmp, hold, call, ret;
  logic [3:0] jmp_addr;
  logic [7:0] pm_addr, pc, from_PS;
  logic       jmp_taken, stack_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_pc  = 8'h00;
  logic       m_jt  = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_stk [$];

  program_sequencer dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .jmp          (jmp),
    .jmp_nz       (jmp_nz),
    .jmp_addr     (jmp_addr),
    .dont_jmp     (dont_jmp),
    .hold         (hold),
    .call         (call),
    .ret          (ret),
    .pm_addr      (pm_addr),
    .pc           (pc),
    .from_PS      (from_PS),
    .jmp_taken    (jmp_taken),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational pm_addr, clock, check registers.
  task automatic step(input bit rn, input bit h, input bit j, input bit jn, input bit dj,
                      input bit c, input bit r, input logic [3:0] a);
    logic [7:0] exp_addr;
    logic [7:0] nxt;
    bit         redir, err_now, do_push, do_pop;
    sync_reset_n = rn; hold = h; jmp = j; jmp_nz = jn; dont_jmp = dj;
    call = c; ret = r; jmp_addr = a;
    #1;
    nxt = m_pc + 8'd1;
    redir = 0; err_now = 0; do_push = 0; do_pop = 0;
    if (!rn) exp_addr = 8'h00;
    else if (h) exp_addr = m_pc;
    else if (STACK_EN && r) begin
      if (m_stk.size() > 0) begin exp_addr = m_stk[$]; redir = 1; do_pop = 1; end
      else begin exp_addr = nxt; err_now = 1; end
    end else if (STACK_EN && c) begin
      exp_addr = {a, 4'h0}; redir = 1;
      if (m_stk.size() < DEPTH) do_push = 1; else err_now = 1;
    end else if (j || (jn && !dj)) begin
      exp_addr = {a, 4'h0}; redir = 1;
    end else exp_addr = nxt;
    check("pm_addr", pm_addr, exp_addr);
    @(posedge clk);
    if (!rn) begin
      m_stk.delete(); m_pc = 8'h00; m_jt = 0; m_err = 0;
    end else begin
      if (do_pop) void'(m_stk.pop_back());
      if (do_push) m_stk.push_back(nxt);
      m_pc = exp_addr; m_jt = redir; m_err = m_err | err_now;
    end
    #1;
    check("pc", pc, m_pc);
    check("from_PS", from_PS, m_pc);
    check("jmp_taken", {7'd0, jmp_taken}, {7'd0, m_jt});
    check("stack_err", {7'd0, stack_err}, {7'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic jump_to(input logic [3:0] a);
    step(1, 0, 1, 0, 0, 0, 0, a);
  endtask

  initial begin
    sync_reset_n = 0; hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0;
    call = 0; ret = 0; jmp_addr = 4'h0;

    // Reset then free-running increment.
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(0, 1, 1, 0, 0, 1, 1, 4'hF);
    check("reset_pc", pc, 8'h00);
    idle(3);
    check("count_pc", pc, 8'h03);

    // Wrap from 0xFF to 0x00.
    jump_to(4'hF);
    idle(15);
    check("pre_wrap_pc", pc, 8'hFF);
    idle(1);
    check("wrap_pc", pc, 8'h00);
    check("wrap_jt", {7'd0, jmp_taken}, 8'h00);

    // Unconditional and conditional jumps.
    jump_to(4'h1);
    idle(2);
    jump_to(4'hA);
    check("jmp_pc", pc, 8'hA0);
    check("jmp_jt", {7'd0, jmp_taken}, 8'h01);
    jump_to(4'h3);
    step(1, 0, 0, 1, 1, 0, 0, 4'h7);
    check("nz_not_taken_pc", pc, 8'h31);
    step(1, 0, 0, 1, 0, 0, 0, 4'h7);
    check("nz_taken_pc", pc, 8'h70);
    step(1, 0, 1, 1, 1, 0, 0, 4'h2);
    step(1, 0, 1, 1, 0, 0, 0, 4'hC);

    // Hold masks a pending jump; release lets it through.
    jump_to(4'h4);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 0, 4'h5);
    check("hold_pc", pc, 8'h40);
    step(1, 0, 1, 0, 0, 0, 0, 4'h5);
    check("release_pc", pc, 8'h50);

    // Call / return (ignored when the stack is compiled out).
    jump_to(4'h1);
    step(1, 0, 0, 0, 0, 1, 0, 4'h8);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 1, 4'h0);
    step(1, 0, 0, 0, 0, 0, 1, 4'h0);
    idle(1);
    step(1, 1, 0, 0, 0, 1, 1, 4'h9);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, 4'(i + 2));
    step(1, 0, 0, 0, 0, 1, 1, 4'hE);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1, 4'h0);

    // Reset in the middle of a call chain.
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    jump_to(4'h2);
    step(1, 0, 0, 0, 0, 1, 0, 4'h6);
    step(1, 0, 0, 0, 0, 1, 0, 4'hB);
    step(0, 0, 0, 0, 0, 1, 0, 4'h3);
    check("mid_reset_pc", pc, 8'h00);
    step(1, 0, 0, 0, 0, 0, 1, 4'h0);
    check("post_reset_ret_pc", pc, 8'h01);

    // Random control traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(31) != 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
           $urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(5) == 0,
           $urandom_range(5) == 0, 4'($urandom_range(15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
